mul5_rr_arbiter: RTL and testbench
==================================

Name: mul5_rr_arbiter

Overview:
- Shares one registered 5x5 signed array multiplier among N_REQ requesters using round-robin arbitration.
- The multiplier registers its 9-bit product on clk when its enable is high and holds it otherwise. This block treats that product register as its single pipeline stage.
- Each requester has a valid/ready request interface. One response channel returns the product tagged with the requester id, under backpressure.
- Sits between the requesting datapaths and the multiplier instance. Drives mul_a, mul_b and mul_en, and reads mul_p.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDW, 2, id width; must satisfy 2^IDW >= N_REQ.
- CNTW, 16, width of the issued-operation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_a  in  5*N_REQ  signed multiplicand; requester i uses bits [5i+4:5i]
- req_b  in  5*N_REQ  signed multiplier; requester i uses bits [5i+4:5i]
- req_ready  out  N_REQ  one-hot grant; a handshake completes when valid and ready are both high
- mul_a  out  5  operand A to the multiplier
- mul_b  out  5  operand B to the multiplier
- mul_en  out  1  multiplier capture enable
- mul_p  in  9  registered multiplier product
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester that owns rsp_p
- rsp_p  out  9  signed product; wired directly from mul_p
- rsp_ovf  out  1  product is not representable in 9 bits; only (-16)*(-16) qualifies
- op_count  out  CNTW  number of operations issued since reset

Behaviour:
- Reset values (async assert, sync release): occ=0, rr_ptr=0, rsp_id=0, rsp_ovf=0, op_count=0.
  - Therefore rsp_valid=0, req_ready=0, mul_en=0.
- State is one occupancy flag, occ, which means "the multiplier register holds an unconsumed product". rsp_valid = occ.
- Issue condition:
  - can_issue = !occ || rsp_ready.
  - issue = can_issue && (|req_valid).
  - mul_en = issue.
- Arbitration:
  - Combinational, round-robin starting from rr_ptr: the first set req_valid bit at index rr_ptr, rr_ptr+1, ... (mod N_REQ) wins.
  - req_ready[g] = issue for the winner g; all other req_ready bits are 0.
  - rr_ptr <= (g+1) mod N_REQ on issue only.
- Operand mux:
  - On issue: mul_a/mul_b = the operands of requester g.
  - Otherwise: mul_a/mul_b = 0. This has no effect because mul_en=0.
- Latency: request handshake in cycle T -> rsp_valid=1 with the product in cycle T+1.
- Throughput: one operation per cycle while rsp_ready=1.
- On issue, the block registers:
  - rsp_id <= g
  - rsp_ovf <= (operand a == -16) && (operand b == -16)
  - occ <= 1
- Response accepted (occ && rsp_ready) with no new issue: occ <= 0. mul_p holds because mul_en=0.
- Simultaneous accept and issue: occ stays 1; rsp_id, rsp_ovf and the product update to the new operation.
- Backpressure (occ && !rsp_ready):
  - no issue, all req_ready=0;
  - rsp_p, rsp_id and rsp_ovf stay stable until accepted.
- Overflow case: (-16)*(-16) produces mul_p = 9'h100 (reads as -256). It is still returned, with rsp_ovf=1. All other operand pairs return the exact product with rsp_ovf=0.
- op_count increments on every issue and wraps modulo 2^CNTW.
- Fairness: a requester that holds req_valid is granted within N_REQ issues.
- Reset mid-operation discards any in-flight product. rsp_valid is 0 in the first cycle after release, whatever mul_p contains.
- req_valid deasserted without a handshake: that request is dropped; the block has no memory of it.

Test Plan:
- Single request, requester 2: a=7, b=-3, rsp_ready=1 -> req_ready[2] in T; in T+1 rsp_valid=1, rsp_id=2, rsp_p=-21 (9'h1EB), rsp_ovf=0; op_count=1.
- All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; the rsp_id sequence matches with 1-cycle lag.
- Backpressure: occ=1 with rsp_ready=0 for 5 cycles while requests pend -> no req_ready, rsp_p/rsp_id stable; releasing rsp_ready gives accept plus new issue in the same cycle.
- Overflow: a=-16, b=-16 -> rsp_p=9'h100, rsp_ovf=1. Then a=-16, b=15 -> rsp_p=-240 (9'h110), rsp_ovf=0.
- Starvation: requesters 0 and 3 always valid, requester 1 raises valid at an arbitrary cycle -> granted within 4 issues; the pointer rotation is checked.
- Reset asserted while occ=1 with a pending response -> rsp_valid, req_ready and op_count are 0 immediately; after release, the first request is granted starting from rr_ptr=0.

Source files
------------

// File: rtl/mul5_rr_arbiter.sv
// Round-robin front end that shares one registered 5x5 signed multiplier among
// N_REQ valid/ready requesters and returns id-tagged products under backpressure.
module mul5_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [5*N_REQ-1:0]   req_a,
    input  logic [5*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [4:0]           mul_a,
    output logic [4:0]           mul_b,
    output logic                 mul_en,
    input  logic [8:0]           mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [8:0]           rsp_p,
    output logic                 rsp_ovf,
    output logic [CNTW-1:0]      op_count
);

    logic                    occ;
    logic [IDW-1:0]          rr_ptr;
    logic [IDW-1:0]          gnt;
    logic [IDW-1:0]          nxt_ptr;
    logic                    issue;
    logic [N_REQ-1:0]        hi_mask;
    logic [N_REQ-1:0]        hi_valid;
    logic [N_REQ-1:0][4:0]   ops_a;
    logic [N_REQ-1:0][4:0]   ops_b;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign ops_a[i]     = req_a[5*i +: 5];
        assign ops_b[i]     = req_b[5*i +: 5];
        assign hi_mask[i]   = (IDW'(i) >= rr_ptr);
        assign req_ready[i] = issue && (gnt == IDW'(i));
    end

    assign hi_valid = req_valid & hi_mask;

    // Lowest set bit at or above rr_ptr wins; otherwise wrap to the lowest set bit.
    always_comb begin
        gnt = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) gnt = IDW'(i);
        end
        if (|hi_valid) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (hi_valid[i]) gnt = IDW'(i);
            end
        end
    end

    // rst_n gates issue so no grant or capture is seen while reset is held.
    assign issue   = rst_n && (!occ || rsp_ready) && (|req_valid);
    assign mul_en  = issue;
    assign mul_a   = issue ? ops_a[gnt] : '0;
    assign mul_b   = issue ? ops_b[gnt] : '0;
    assign nxt_ptr = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + IDW'(1);

    assign rsp_valid = occ;
    assign rsp_p     = mul_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= 1'b0;
            rr_ptr   <= '0;
            rsp_id   <= '0;
            rsp_ovf  <= 1'b0;
            op_count <= '0;
        end else if (issue) begin
            occ      <= 1'b1;
            rr_ptr   <= nxt_ptr;
            rsp_id   <= gnt;
            rsp_ovf  <= (mul_a == 5'b10000) && (mul_b == 5'b10000);
            op_count <= op_count + CNTW'(1);
        end else if (rsp_ready) begin
            occ      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul5_rr_arbiter.sv
// Directed bench for mul5_rr_arbiter with a behavioural registered multiplier.
module tb_mul5_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [19:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [4:0]  mul_a, mul_b;
    logic        mul_en;
    logic [8:0]  mul_p = 9'h0;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [8:0]  rsp_p;
    logic        rsp_ovf;
    logic [15:0] op_count;

    int n_cmp = 0;
    int n_err = 0;

    mul5_rr_arbiter #(.N_REQ(4), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_p(rsp_p), .rsp_ovf(rsp_ovf), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Registered 5x5 signed multiplier, 9-bit truncated product.
    always @(posedge clk)
        if (mul_en)
            mul_p <= $signed({{4{mul_a[4]}}, mul_a}) * $signed({{4{mul_b[4]}}, mul_b});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [4:0] a, input logic [4:0] b);
        req_a[5*i +: 5] = a;
        req_b[5*i +: 5] = b;
    endtask

    // Requester i: a = i+1, b = -(i+2); products -2, -6, -12, -20.
    logic [8:0] prod_tab [4] = '{9'h1FE, 9'h1FA, 9'h1F4, 9'h1EC};
    // Starvation run: 0 and 3 always valid, 1 joins before step 3.
    int         starve_g [7] = '{3, 0, 3, 0, 1, 3, 0};

    initial begin
        int g;
        int waited;
        rst_n = 1'b0; req_valid = 4'h0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #2;
        req_valid = 4'hF;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mul_en",    32'(mul_en),    32'd0);
        chk("rst_op_count",  32'(op_count),  32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_rsp_ovf",   32'(rsp_ovf),   32'd0);
        req_valid = 4'h0;
        tick(); tick();
        rst_n = 1'b1;

        // Single request from requester 2: 7 * -3 = -21.
        set_op(2, 5'h07, 5'h1D);
        req_valid = 4'b0100; rsp_ready = 1'b1;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        chk("single_en",    32'(mul_en),    32'd1);
        chk("single_a",     32'(mul_a),     32'h07);
        chk("single_b",     32'(mul_b),     32'h1D);
        tick();
        req_valid = 4'h0;
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id",    32'(rsp_id),    32'd2);
        chk("single_p",     32'(rsp_p),     32'h1EB);
        chk("single_ovf",   32'(rsp_ovf),   32'd0);
        chk("single_cnt",   32'(op_count),  32'd1);
        tick();
        chk("single_drain", 32'(rsp_valid), 32'd0);

        // All valid, pointer at 3 after the previous grant of 2.
        set_op(0, 5'h01, 5'h1E);
        set_op(1, 5'h02, 5'h1D);
        set_op(2, 5'h03, 5'h1C);
        set_op(3, 5'h04, 5'h1B);
        req_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            g = (3 + i) % 4;
            #1;
            chk("rr_ready", 32'(req_ready), 32'(1 << g));
            tick();
            chk("rr_id", 32'(rsp_id), 32'(g));
            chk("rr_p",  32'(rsp_p),  32'(prod_tab[g]));
        end
        chk("rr_cnt", 32'(op_count), 32'd7);

        // Backpressure: response for requester 0 held for 5 cycles.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_en",    32'(mul_en),    32'd0);
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id",    32'(rsp_id),    32'd0);
            chk("bp_p",     32'(rsp_p),     32'h1FE);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h2);
        tick();
        chk("bp_release_id",  32'(rsp_id),   32'd1);
        chk("bp_release_p",   32'(rsp_p),    32'h1FA);
        chk("bp_release_cnt", 32'(op_count), 32'd8);
        req_valid = 4'h0;
        tick();
        chk("bp_drain", 32'(rsp_valid), 32'd0);

        // Overflow corner then its neighbour.
        set_op(0, 5'h10, 5'h10);
        req_valid = 4'b0001;
        #1;
        chk("ovf_ready", 32'(req_ready), 32'h1);
        tick();
        chk("ovf_p",   32'(rsp_p),   32'h100);
        chk("ovf_flag", 32'(rsp_ovf), 32'd1);
        chk("ovf_id",  32'(rsp_id),  32'd0);
        set_op(0, 5'h10, 5'h0F);
        #1;
        chk("novf_ready", 32'(req_ready), 32'h1);
        tick();
        chk("novf_p",    32'(rsp_p),     32'h110);
        chk("novf_flag", 32'(rsp_ovf),   32'd0);
        chk("novf_valid", 32'(rsp_valid), 32'd1);
        chk("novf_cnt",  32'(op_count),  32'd10);
        req_valid = 4'h0;
        tick();

        // Starvation: pointer at 1, requesters 0 and 3 hog, 1 joins late.
        req_valid = 4'b1001;
        waited = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) req_valid = 4'b1011;
            #1;
            chk("starve_ready", 32'(req_ready), 32'(1 << starve_g[i]));
            if (i >= 3 && waited >= 0) begin
                waited++;
                if (req_ready[1]) begin
                    chk("starve_bound", 32'(waited <= 4), 32'd1);
                    waited = -1;
                end
            end
            tick();
            chk("starve_id", 32'(rsp_id), 32'(starve_g[i]));
        end
        chk("starve_granted", 32'(waited), 32'hFFFF_FFFF);
        chk("starve_cnt", 32'(op_count), 32'd17);

        // Reset with a response pending; pointer is 1 beforehand.
        req_valid = 4'b0011;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd0);
        chk("mrst_cnt",   32'(op_count),  32'd0);
        chk("mrst_en",    32'(mul_en),    32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post_rst_id",  32'(rsp_id),   32'd0);
        chk("post_rst_p",   32'(rsp_p),    32'h110);
        chk("post_rst_cnt", 32'(op_count), 32'd1);
        req_valid = 4'h0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
